wb_interconnect_nxn_rr: RTL and testbench

Registered-grant Wishbone crossbar connecting N_INITIATORS to N_TARGETS with per-target address masks, per-target round-robin arbitration, and locked grants that persist across a bus cycle. Each target also has a bus-timeout watchdog, and an internal error responder answers unmapped addresses. It sits between CPU/DMA initiators and peripheral/memory targets and is the drop-in replacement for the purely combinational NxN interconnect where fairness, address-hole safety, or hung-target recovery is needed.

---
 rtl/wb_interconnect_nxn_rr_pkg.sv | 14 +
 rtl/wb_interconnect_rr_arb.sv | 73 +++++++
 rtl/wb_interconnect_nxn_rr.sv | 172 +++++++++++++++++
 tb/tb_wb_interconnect_nxn_rr.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_interconnect_nxn_rr_pkg.sv
// Shared definitions for the registered-grant NxN Wishbone crossbar:
// arbiter state encoding and index-width helper.
package wb_interconnect_nxn_rr_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_interconnect_rr_arb.sv
// Per-target round-robin arbiter with a locked grant that persists
// while the owner holds its bus cycle on this target.
module wb_interconnect_rr_arb
    import wb_interconnect_nxn_rr_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW = id_width(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             lock_i,
    input  logic             release_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             granted_o
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [N_REQ-1:0] req_m;
    logic [IW-1:0]    win;
    logic             found;
    logic             rearb;

    always_comb begin
        req_m = req_i;
        // The releasing owner must not immediately win its own grant back.
        if (state_q == ARB_GRANTED) begin
            req_m = req_i & ~gnt_q;
        end
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_m[(int'(last_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(last_q) + k) % N_REQ);
            end
        end
        rearb   = (state_q == ARB_IDLE) || !lock_i || release_i;
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        if (rearb) begin
            if (found) begin
                state_d = ARB_GRANTED;
                gnt_d   = N_REQ'(1) << win;
                last_d  = win;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = last_q;
    assign granted_o = (state_q == ARB_GRANTED);

endmodule

// File: rtl/wb_interconnect_nxn_rr.sv
// NxN Wishbone crossbar: masked decode, per-target round-robin locked
// grants, per-target stall watchdog and an unmapped-address error responder.
module wb_interconnect_nxn_rr
    import wb_interconnect_nxn_rr_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 2,
    parameter int N_TARGETS      = 2,
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR =
        {32'h2000_0000, 32'h1000_0000},
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR_MASK =
        {32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]   adr_i,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   dat_w_i,
    input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0] sel_i,
    input  logic [N_INITIATORS-1:0]                 cyc_i,
    input  logic [N_INITIATORS-1:0]                 stb_i,
    input  logic [N_INITIATORS-1:0]                 we_i,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   dat_r_o,
    output logic [N_INITIATORS-1:0]                 ack_o,
    output logic [N_INITIATORS-1:0]                 err_o,
    output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]      tadr_o,
    output logic [N_TARGETS*WB_DATA_WIDTH-1:0]      tdat_w_o,
    output logic [N_TARGETS*WB_DATA_WIDTH/8-1:0]    tsel_o,
    output logic [N_TARGETS-1:0]                    tcyc_o,
    output logic [N_TARGETS-1:0]                    tstb_o,
    output logic [N_TARGETS-1:0]                    twe_o,
    input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]      tdat_r_i,
    input  logic [N_TARGETS-1:0]                    tack_i,
    input  logic [N_TARGETS-1:0]                    terr_i
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int NI = N_INITIATORS;
    localparam int NT = N_TARGETS;
    localparam int IW = id_width(NI);
    localparam int TW = id_width(NT);
    localparam int CW = id_width(TIMEOUT_CYCLES);

    logic [NI-1:0] hit;
    logic [TW-1:0] tgt [NI];
    logic [NI-1:0] unmapped;
    logic [NI-1:0] err_pend_q, err_pend_d;
    logic [NI-1:0] req [NT];
    logic [NI-1:0] gnt_oh [NT];
    logic [IW-1:0] own [NT];
    logic [NT-1:0] granted, hold, rel, stalled;
    logic [NT-1:0] to_q, to_d;
    logic [CW-1:0] cnt_q [NT], cnt_d [NT];

    // Lowest-numbered matching target wins, hence the descending scan.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            hit[i] = 1'b0;
            tgt[i] = '0;
            for (int t = NT - 1; t >= 0; t--) begin
                if (cyc_i[i] && stb_i[i] &&
                    ((adr_i[i*AW +: AW] & T_ADR_MASK[t*AW +: AW])
                     == T_ADR[t*AW +: AW])) begin
                    hit[i] = 1'b1;
                    tgt[i] = TW'(t);
                end
            end
            unmapped[i]   = cyc_i[i] & stb_i[i] & ~hit[i];
            err_pend_d[i] = unmapped[i] & ~err_pend_q[i];
        end
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NI; i++) begin
                req[t][i] = hit[i] && (tgt[i] == TW'(t));
            end
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_arb
        wb_interconnect_rr_arb #(
            .N_REQ(NI)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (req[t]),
            .lock_i   (hold[t]),
            .release_i(to_q[t]),
            .gnt_o    (gnt_oh[t]),
            .gnt_idx_o(own[t]),
            .granted_o(granted[t])
        );
    end

    always_comb begin
        tadr_o   = '0;
        tdat_w_o = '0;
        tsel_o   = '0;
        tcyc_o   = '0;
        tstb_o   = '0;
        twe_o    = '0;
        for (int t = 0; t < NT; t++) begin
            hold[t] = cyc_i[own[t]] &&
                      (!stb_i[own[t]] ||
                       (hit[own[t]] && (tgt[own[t]] == TW'(t))));
            rel[t]  = granted[t] & (~hold[t] | to_q[t]);
            if (granted[t]) begin
                tadr_o[t*AW +: AW]   = adr_i[int'(own[t])*AW +: AW];
                tdat_w_o[t*DW +: DW] = dat_w_i[int'(own[t])*DW +: DW];
                tsel_o[t*SW +: SW]   = sel_i[int'(own[t])*SW +: SW];
                tcyc_o[t]            = cyc_i[own[t]] & ~to_q[t];
                tstb_o[t]            = stb_i[own[t]] & ~to_q[t];
                twe_o[t]             = we_i[own[t]];
            end
        end
    end

    // A late tack in the timeout cycle suppresses the watchdog error.
    always_comb begin
        ack_o   = '0;
        err_o   = err_pend_q;
        dat_r_o = '0;
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NI; i++) begin
                if (gnt_oh[t][i]) begin
                    ack_o[i] = ack_o[i] | tack_i[t];
                    err_o[i] = err_o[i] | terr_i[t] |
                               (to_q[t] & ~tack_i[t]);
                    dat_r_o[i*DW +: DW] = dat_r_o[i*DW +: DW] |
                                          tdat_r_i[t*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            stalled[t] = tcyc_o[t] & tstb_o[t] & ~tack_i[t] & ~terr_i[t];
            cnt_d[t]   = cnt_q[t];
            to_d[t]    = 1'b0;
            if (!granted[t] || rel[t] || tack_i[t] || terr_i[t]) begin
                cnt_d[t] = '0;
            end else if (stalled[t]) begin
                if ((TIMEOUT_CYCLES != 0) &&
                    (cnt_q[t] == CW'(TIMEOUT_CYCLES - 1))) begin
                    to_d[t]  = 1'b1;
                    cnt_d[t] = '0;
                end else begin
                    cnt_d[t] = cnt_q[t] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pend_q <= '0;
            to_q       <= '0;
            for (int t = 0; t < NT; t++) begin
                cnt_q[t] <= '0;
            end
        end else begin
            err_pend_q <= err_pend_d;
            to_q       <= to_d;
            for (int t = 0; t < NT; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
        end
    end

endmodule

// File: tb/tb_wb_interconnect_nxn_rr.sv
// Directed bench for the NxN round-robin crossbar: decode, contention,
// lock, unmapped error, watchdog timeout and mid-transfer reset.
module tb_wb_interconnect_nxn_rr;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NI = 2;
    localparam int NT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NI*AW-1:0] adr;
    logic [NI*DW-1:0] dat_w;
    logic [NI*SW-1:0] sel;
    logic [NI-1:0]    cyc, stb, we;
    logic [NI*DW-1:0] dat_r;
    logic [NI-1:0]    ack, err;
    logic [NT*AW-1:0] tadr;
    logic [NT*DW-1:0] tdat_w, tdat_r;
    logic [NT*SW-1:0] tsel;
    logic [NT-1:0]    tcyc, tstb, twe, tack, terr;

    int checks   = 0;
    int failures = 0;

    wb_interconnect_nxn_rr #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .N_INITIATORS  (NI),
        .N_TARGETS     (NT),
        .T_ADR         (64'h2000_0000_1000_0000),
        .T_ADR_MASK    (64'hF000_0000_F000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .adr_i   (adr),
        .dat_w_i (dat_w),
        .sel_i   (sel),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .dat_r_o (dat_r),
        .ack_o   (ack),
        .err_o   (err),
        .tadr_o  (tadr),
        .tdat_w_o(tdat_w),
        .tsel_o  (tsel),
        .tcyc_o  (tcyc),
        .tstb_o  (tstb),
        .twe_o   (twe),
        .tdat_r_i(tdat_r),
        .tack_i  (tack),
        .terr_i  (terr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        cyc[i] = c;
        stb[i] = c;
        we[i]  = w;
        adr[i*AW +: AW]   = a;
        dat_w[i*DW +: DW] = d;
        sel[i*SW +: SW]   = '1;
    endtask

    task automatic idle_all;
        cyc = '0; stb = '0; we = '0; adr = '0; dat_w = '0; sel = '0;
        tack = '0; terr = '0; tdat_r = '0;
    endtask

    task automatic round(input string tag, input logic [1:0] exp);
        drv(0, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        drv(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        tick;
        tack[1] = 1'b1;
        #1 check(tag, ack, exp);
        tick;
        idle_all;
        tick;
    endtask

    initial begin
        idle_all;
        rst = 1'b1;
        drv(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        tick;
        tick;
        #1 check("rst_t", {tcyc, tstb, twe}, 0);
        check("rst_resp", {ack, err}, 0);
        check("rst_tadr", tadr, 0);
        rst = 1'b0;
        idle_all;
        tick;

        // decode with one wait state
        drv(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
        #1 check("dec_lat", tstb, 0);
        tick;
        #1 check("dec_tadr", tadr[31:0], 32'h1000_0004);
        check("dec_wait_ack", ack, 0);
        tick;
        tack[0] = 1'b1;
        tdat_r[31:0] = 32'hDEAD_BEEF;
        #1 check("dec_ack", ack, 2'b01);
        check("dec_dat", dat_r[31:0], 32'hDEAD_BEEF);
        check("dec_dat_other", dat_r[63:32], 0);
        tick;
        idle_all;
        #1 check("dec_done", ack, 0);
        tick;

        // contention on target1 with same-edge re-grant
        drv(0, 1'b1, 1'b1, 32'h2000_0000, 32'hAAAA_0000);
        drv(1, 1'b1, 1'b1, 32'h2000_0000, 32'hBBBB_0001);
        #1 check("cont_lat", tstb, 0);
        tick;
        tack[1] = 1'b1;
        #1 check("cont_first", ack, 2'b01);
        check("cont_tdat0", tdat_w[63:32], 32'hAAAA_0000);
        tick;
        tack[1] = 1'b0;
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("cont_loser_wait", ack, 0);
        check("cont_rel_tcyc", tcyc[1], 0);
        tick;
        tack[1] = 1'b1;
        #1 check("cont_regrant", ack, 2'b10);
        check("cont_tdat1", tdat_w[63:32], 32'hBBBB_0001);
        tick;
        idle_all;
        tick;
        round("alt_init0", 2'b01);
        round("alt_init1", 2'b10);

        // init1 locks target0 for four writes
        drv(1, 1'b1, 1'b1, 32'h1000_0000, 32'h1);
        tick;
        drv(0, 1'b1, 1'b0, 32'h1000_0100, 32'h0);
        tack[0] = 1'b1;
        #1 check("lock_w0", ack, 2'b10);
        check("lock_adr0", tadr[31:0], 32'h1000_0000);
        for (int k = 1; k < 4; k++) begin
            tick;
            drv(1, 1'b1, 1'b1, 32'h1000_0000 + 32'(4 * k), 32'(k + 1));
            #1 check("lock_w", ack, 2'b10);
            check("lock_adr", tadr[31:0], 32'h1000_0000 + 32'(4 * k));
        end
        tick;
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tack[0] = 1'b0;
        #1 check("lock_wait_tstb", tstb[0], 0);
        check("lock_wait_ack", ack, 0);
        tick;
        tack[0] = 1'b1;
        #1 check("lock_init0", ack, 2'b01);
        check("lock_init0_adr", tadr[31:0], 32'h1000_0100);
        tick;
        idle_all;
        tick;

        // unmapped address
        drv(0, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
        #1 check("unm_now", err, 0);
        tick;
        #1 check("unm_err", err, 2'b01);
        check("unm_t", {tcyc, tstb}, 0);
        check("unm_ack", ack, 0);
        check("unm_dat", dat_r, 0);
        tick;
        #1 check("unm_gap", err, 0);
        tick;
        #1 check("unm_refire", err, 2'b01);
        tick;
        idle_all;
        #1 check("unm_clear", err, 0);
        tick;

        // watchdog on target1
        drv(1, 1'b1, 1'b0, 32'h2000_0010, 32'h0);
        tick;
        #1 check("to_tstb", tstb[1], 1);
        tick;
        tick;
        tick;
        #1 check("to_pre", err, 0);
        tick;
        #1 check("to_err", err, 2'b10);
        check("to_tcyc", tcyc[1], 0);
        tick;
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(0, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        #1 check("to_rel", {tcyc[1], err}, 0);
        tick;
        tack[1] = 1'b1;
        #1 check("to_regrant", ack, 2'b01);
        tick;
        idle_all;
        tick;

        // late tack in the timeout cycle wins
        drv(1, 1'b1, 1'b0, 32'h2000_0020, 32'h0);
        repeat (5) tick;
        tack[1] = 1'b1;
        tdat_r[63:32] = 32'h5555_AAAA;
        #1 check("late_ack", ack, 2'b10);
        check("late_err", err, 0);
        check("late_dat", dat_r[63:32], 32'h5555_AAAA);
        tick;
        idle_all;
        tick;

        // reset while target0 is waiting
        drv(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        tick;
        drv(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        #1 check("rm_tstb", tstb[0], 1);
        tick;
        rst = 1'b1;
        tdat_r[31:0] = 32'h1234_5678;
        tick;
        #1 check("rm_out", {ack, err, tcyc, tstb, twe}, 0);
        check("rm_tadr", tadr, 0);
        check("rm_dat", dat_r, 0);
        tick;
        #1 check("rm_hold", tcyc, 0);
        rst = 1'b0;
        tick;
        tack[0] = 1'b1;
        #1 check("rm_first", ack, 2'b01);
        tick;
        idle_all;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
